// File: rtl/obi_interconnect_pkg.sv
`default_nettype none
// ============================================================================
// Module      : obi_interconnect_pkg
// Description : Shared constants for the OBI system-bus interconnect.
//               OBI_ADDR_W / OBI_DATA_W / OBI_BE_W : OBI bus field widths
//               OBI_MAX_OUTSTANDING                : default ID FIFO depth
// Revision    : 1.0 - initial release
// ============================================================================
package obi_interconnect_pkg;
   localparam int OBI_ADDR_W          = 32;
   localparam int OBI_DATA_W          = 32;
   localparam int OBI_BE_W            = 4;
   localparam int OBI_MAX_OUTSTANDING = 2;
endpackage
`default_nettype wire

// File: rtl/obi_id_fifo.sv
`default_nettype none
// ============================================================================
// Module      : obi_id_fifo
// Description : In-order FIFO of master IDs for granted-but-unanswered
//               transactions.
//   clk      in  : clock
//   rst      in  : synchronous active-high reset (empties the FIFO)
//   i_push   in  : write i_data (ignored when full)
//   i_pop    in  : drop the head entry (ignored when empty)
//   i_data   in  : ID to store
//   o_head   out : oldest stored ID
//   o_full   out : count == DEPTH
//   o_empty  out : count == 0
// Revision    : 1.0 - initial release
// ============================================================================
module obi_id_fifo #(
   parameter int WIDTH = 2,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_head,
   output logic             o_full,
   output logic             o_empty
);
   localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int c_CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0]   r_mem [DEPTH];
   logic [c_PTR_W-1:0] r_wptr;
   logic [c_PTR_W-1:0] r_rptr;
   logic [c_CNT_W-1:0] r_count;
   logic               w_push;
   logic               w_pop;

   // Pointers wrap at DEPTH, which need not be a power of two.
   function automatic logic [c_PTR_W-1:0] next_ptr(input logic [c_PTR_W-1:0] ptr);
      if (ptr == c_PTR_W'(DEPTH - 1)) begin
         return '0;
      end
      return ptr + c_PTR_W'(1);
   endfunction

   assign o_full  = (r_count == c_CNT_W'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_head  = r_mem[r_rptr];
   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wptr] <= i_data;
            r_wptr        <= next_ptr(r_wptr);
         end
         if (w_pop) begin
            r_rptr <= next_ptr(r_rptr);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + c_CNT_W'(1);
         end else if (w_pop && !w_push) begin
            r_count <= r_count - c_CNT_W'(1);
         end
      end
   end
endmodule
`default_nettype wire

// File: rtl/obi_interconnect_slave_port.sv
`default_nettype none
// ============================================================================
// Module      : obi_interconnect_slave_port
// Description : Per-slave stage of the OBI interconnect. Forwards the
//               selected master's request to the slave, returns the grant,
//               tracks granted master IDs in order and routes responses back.
//   clk_i, rst_i                    : clock, synchronous active-high reset
//   master_sel_int_i, granted_master_i : selector result
//   master_addr/we/be/wdata_i       : per-master request fields
//   master_gnt/rvalid/rdata_o       : per-master grant and response
//   slave_req/addr/we/be/wdata_o    : request to the slave
//   slave_gnt_i, slave_rvalid_i, slave_rdata_i : slave handshake/response
//   resp_err_o                      : sticky, response with nothing outstanding
// Revision    : 1.0 - initial release
// ============================================================================
module obi_interconnect_slave_port
   import obi_interconnect_pkg::*;
#(
   parameter int MASTERS         = 3,
   parameter int MASTER_BITS     = (MASTERS == 1) ? 1 : $clog2(MASTERS),
   parameter int MAX_OUTSTANDING = OBI_MAX_OUTSTANDING
) (
   input  logic                               clk_i,
   input  logic                               rst_i,
   input  logic [MASTER_BITS-1:0]             master_sel_int_i,
   input  logic                               granted_master_i,
   input  logic [MASTERS-1:0][OBI_ADDR_W-1:0] master_addr_i,
   input  logic [MASTERS-1:0]                 master_we_i,
   input  logic [MASTERS-1:0][OBI_BE_W-1:0]   master_be_i,
   input  logic [MASTERS-1:0][OBI_DATA_W-1:0] master_wdata_i,
   output logic [MASTERS-1:0]                 master_gnt_o,
   output logic [MASTERS-1:0]                 master_rvalid_o,
   output logic [MASTERS-1:0][OBI_DATA_W-1:0] master_rdata_o,
   output logic                               slave_req_o,
   output logic [OBI_ADDR_W-1:0]              slave_addr_o,
   output logic                               slave_we_o,
   output logic [OBI_BE_W-1:0]                slave_be_o,
   output logic [OBI_DATA_W-1:0]              slave_wdata_o,
   input  logic                               slave_gnt_i,
   input  logic                               slave_rvalid_i,
   input  logic [OBI_DATA_W-1:0]              slave_rdata_i,
   output logic                               resp_err_o
);
   logic                   w_full;
   logic                   w_empty;
   logic [MASTER_BITS-1:0] w_head;
   logic                   w_accept;
   logic                   w_resp;
   logic                   r_resp_err;

   // Full is the registered state only: a same-cycle pop does not free a slot,
   // which keeps slave_gnt_i -> push off the rvalid path.
   assign slave_req_o   = granted_master_i & ~w_full & ~rst_i;
   assign slave_addr_o  = master_addr_i[master_sel_int_i];
   assign slave_we_o    = master_we_i[master_sel_int_i];
   assign slave_be_o    = master_be_i[master_sel_int_i];
   assign slave_wdata_o = master_wdata_i[master_sel_int_i];

   assign w_accept = slave_req_o & slave_gnt_i;
   assign w_resp   = slave_rvalid_i & ~w_empty & ~rst_i;

   obi_id_fifo #(
      .WIDTH (MASTER_BITS),
      .DEPTH (MAX_OUTSTANDING)
   ) u_id_fifo (
      .clk     (clk_i),
      .rst     (rst_i),
      .i_push  (w_accept),
      .i_pop   (w_resp),
      .i_data  (master_sel_int_i),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   generate
      for (genvar m = 0; m < MASTERS; m++) begin : g_master
         assign master_gnt_o[m]    = w_accept & (master_sel_int_i == MASTER_BITS'(m));
         assign master_rvalid_o[m] = w_resp & (w_head == MASTER_BITS'(m));
         assign master_rdata_o[m]  = slave_rdata_i;
      end
   endgenerate

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_resp_err <= 1'b0;
      end else if (slave_rvalid_i && w_empty) begin
         r_resp_err <= 1'b1;
      end
   end

   assign resp_err_o = r_resp_err;
endmodule
`default_nettype wire

// File: tb/tb_obi_interconnect_slave_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_obi_interconnect_slave_port
// Description : Self-checking bench for obi_interconnect_slave_port.
//               Directed scenarios followed by random traffic, all checked
//               against a queue-based model of outstanding master IDs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_obi_interconnect_slave_port;
   localparam int MASTERS = 3;
   localparam int MB      = 2;
   localparam int MAXO    = 2;

   logic                    clk = 1'b0;
   logic                    rst_i;
   logic [MB-1:0]           master_sel_int_i;
   logic                    granted_master_i;
   logic [MASTERS-1:0][31:0] master_addr_i;
   logic [MASTERS-1:0]      master_we_i;
   logic [MASTERS-1:0][3:0] master_be_i;
   logic [MASTERS-1:0][31:0] master_wdata_i;
   logic [MASTERS-1:0]      master_gnt_o;
   logic [MASTERS-1:0]      master_rvalid_o;
   logic [MASTERS-1:0][31:0] master_rdata_o;
   logic                    slave_req_o;
   logic [31:0]             slave_addr_o;
   logic                    slave_we_o;
   logic [3:0]              slave_be_o;
   logic [31:0]             slave_wdata_o;
   logic                    slave_gnt_i;
   logic                    slave_rvalid_i;
   logic [31:0]             slave_rdata_i;
   logic                    resp_err_o;

   int n_checks   = 0;
   int n_failures = 0;

   // Model state: IDs granted but not yet answered, oldest first.
   int m_q[$];
   bit m_err;
   bit rand_fields = 1'b1;

   always #5 clk = ~clk;

   obi_interconnect_slave_port #(
      .MASTERS         (MASTERS),
      .MAX_OUTSTANDING (MAXO)
   ) dut (
      .clk_i            (clk),
      .rst_i            (rst_i),
      .master_sel_int_i (master_sel_int_i),
      .granted_master_i (granted_master_i),
      .master_addr_i    (master_addr_i),
      .master_we_i      (master_we_i),
      .master_be_i      (master_be_i),
      .master_wdata_i   (master_wdata_i),
      .master_gnt_o     (master_gnt_o),
      .master_rvalid_o  (master_rvalid_o),
      .master_rdata_o   (master_rdata_o),
      .slave_req_o      (slave_req_o),
      .slave_addr_o     (slave_addr_o),
      .slave_we_o       (slave_we_o),
      .slave_be_o       (slave_be_o),
      .slave_wdata_o    (slave_wdata_o),
      .slave_gnt_i      (slave_gnt_i),
      .slave_rvalid_i   (slave_rvalid_i),
      .slave_rdata_i    (slave_rdata_i),
      .resp_err_o       (resp_err_o)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_failures++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs, check outputs against the model, then
   // advance the model by the rules for this cycle.
   task automatic step(input bit rst, input bit gm, input int sel, input bit sgnt,
                       input bit srv, input logic [31:0] rdata);
      bit                 exp_req;
      logic [MASTERS-1:0] exp_gnt;
      logic [MASTERS-1:0] exp_rv;
      @(negedge clk);
      rst_i            = rst;
      granted_master_i = gm;
      master_sel_int_i = MB'(sel);
      slave_gnt_i      = sgnt;
      slave_rvalid_i   = srv;
      slave_rdata_i    = rdata;
      if (rand_fields) begin
         for (int m = 0; m < MASTERS; m++) begin
            master_addr_i[m]  = $urandom;
            master_we_i[m]    = 1'($urandom);
            master_be_i[m]    = 4'($urandom);
            master_wdata_i[m] = $urandom;
         end
      end
      #1;
      exp_req = gm && (m_q.size() < MAXO) && !rst;
      exp_gnt = '0;
      exp_rv  = '0;
      if (exp_req && sgnt) exp_gnt[sel] = 1'b1;
      if (srv && m_q.size() > 0 && !rst) exp_rv[m_q[0]] = 1'b1;

      check("slave_req", 64'(slave_req_o), 64'(exp_req));
      check("master_gnt", 64'(master_gnt_o), 64'(exp_gnt));
      check("master_rvalid", 64'(master_rvalid_o), 64'(exp_rv));
      check("resp_err", 64'(resp_err_o), 64'(m_err));
      check("slave_addr", 64'(slave_addr_o), 64'(master_addr_i[sel]));
      check("slave_ctrl", {59'd0, slave_we_o, slave_be_o},
            {59'd0, master_we_i[sel], master_be_i[sel]});
      check("slave_wdata", 64'(slave_wdata_o), 64'(master_wdata_i[sel]));
      for (int m = 0; m < MASTERS; m++) begin
         check("master_rdata", 64'(master_rdata_o[m]), 64'(rdata));
      end

      // Advance the model.
      if (rst) begin
         m_q.delete();
         m_err = 1'b0;
      end else begin
         if (srv) begin
            if (m_q.size() == 0) m_err = 1'b1;
            else void'(m_q.pop_front());
         end
         if (exp_req && sgnt) m_q.push_back(sel);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, $urandom);
   endtask

   initial begin
      rst_i = 1'b1; granted_master_i = 1'b0; master_sel_int_i = '0;
      slave_gnt_i = 1'b0; slave_rvalid_i = 1'b0; slave_rdata_i = '0;
      master_addr_i = '0; master_we_i = '0; master_be_i = '0; master_wdata_i = '0;
      m_err = 1'b0;

      // Reset, with requests pending so forced-low outputs are exercised.
      step(1, 1, 1, 1, 1, 32'h1);
      step(1, 1, 2, 1, 0, 32'h2);

      // Single read from master 1, answered two cycles after the grant.
      step(0, 1, 1, 1, 0, $urandom);
      step(0, 0, 0, 0, 0, $urandom);
      step(0, 0, 0, 0, 1, 32'hDEAD_BEEF);
      check("single_read_rdata", 64'(master_rdata_o[1]), 64'hDEAD_BEEF);
      idle(1);

      // Back-to-back grants to masters 2 then 0, responses in order.
      step(0, 1, 2, 1, 0, $urandom);
      step(0, 1, 0, 1, 0, $urandom);
      step(0, 0, 0, 0, 1, 32'h2222_2222);
      step(0, 0, 0, 0, 1, 32'h0000_0000);

      // Fill the FIFO; a pop in the full cycle does not release the request.
      step(0, 1, 0, 1, 0, $urandom);
      step(0, 1, 1, 1, 0, $urandom);
      step(0, 1, 2, 1, 0, $urandom);
      step(0, 1, 2, 1, 1, $urandom);
      step(0, 1, 2, 1, 0, $urandom);
      step(0, 0, 0, 0, 1, $urandom);
      step(0, 0, 0, 0, 1, $urandom);

      // Slave stall for three cycles with master 1's fields held steady.
      rand_fields = 1'b0;
      for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, $urandom);
      rand_fields = 1'b1;
      idle(1);

      // Spurious response with nothing outstanding: error is sticky.
      step(0, 0, 0, 0, 1, $urandom);
      idle(3);
      step(1, 0, 0, 0, 0, $urandom);

      // Reset with one transaction outstanding, then a stray response.
      step(0, 1, 1, 1, 0, $urandom);
      step(1, 1, 0, 1, 1, $urandom);
      step(0, 0, 0, 0, 1, $urandom);
      idle(2);
      step(1, 0, 0, 0, 0, $urandom);

      // Random traffic; responses mostly only when something is outstanding.
      for (int i = 0; i < 3000; i++) begin
         bit rv;
         rv = (m_q.size() > 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 40) == 0);
         step($urandom_range(0, 150) == 0, 1'($urandom), $urandom_range(0, MASTERS - 1),
              1'($urandom), rv, $urandom);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/obi_interconnect_slave_port.md
# obi_interconnect_slave_port

Per-slave port stage of the OBI system-bus interconnect, directly downstream of the master selector. It receives the selector's winning-master index and grant flag and drives the selected master's request onto the slave. It returns the slave's `gnt` to that master, records the granted master's index in an in-order ID FIFO, and routes each later `rvalid`/`rdata` back to the master that issued the request. One instance sits in front of every slave.

## Interface
- `MASTERS`, 3: number of bus masters.
- `MASTER_BITS`, `MASTERS==1 ? 1 : $clog2(MASTERS)`: master index width.
- `MAX_OUTSTANDING`, 2: ID FIFO depth, i.e. the number of granted-but-unanswered transactions; ≥1.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset; synchronous, active-high.
- `master_sel_int_i` in MASTER_BITS: winning master index from the selector.
- `granted_master_i` in 1: selector found a requesting master that targets this slave.
- `master_addr_i` in 32 x [MASTERS]: per-master address.
- `master_we_i` in 1 x [MASTERS]: per-master write enable.
- `master_be_i` in 4 x [MASTERS]: per-master byte enables.
- `master_wdata_i` in 32 x [MASTERS]: per-master write data.
- `master_gnt_o` out 1 x [MASTERS]: grant to each master.
- `master_rvalid_o` out 1 x [MASTERS]: response valid to each master.
- `master_rdata_o` out 32 x [MASTERS]: response data to each master.
- `slave_req_o` out 1: request to slave.
- `slave_addr_o` out 32, `slave_we_o` out 1, `slave_be_o` out 4, `slave_wdata_o` out 32: forwarded from the selected master.
- `slave_gnt_i` in 1: slave accepted the request.
- `slave_rvalid_i` in 1, `slave_rdata_i` in 32: slave response.
- `resp_err_o` out 1: sticky flag, set when `rvalid` arrives with no outstanding transaction.

## Operation
- FIFO full means `count == MAX_OUTSTANDING`.
- `slave_req_o = granted_master_i & !full`. A pop in the same cycle does not unblock a full FIFO.
- Slave address/control/data fields mux from `master_*_i[master_sel_int_i]` at all times. Fields are don't-care when `slave_req_o` is 0.
- `master_gnt_o[m] = slave_req_o & slave_gnt_i & (m == master_sel_int_i)`. All other masters get 0.
- Accept = `slave_req_o & slave_gnt_i`. On accept, push `master_sel_int_i` into the ID FIFO.
- Response: when `slave_rvalid_i` is high and the FIFO is non-empty:
  - assert `master_rvalid_o[head]`;
  - pop the head.
- `master_rdata_o[m] = slave_rdata_i` for every m. Only the rvalid line selects the destination master.
- `slave_rvalid_i` with the FIFO empty: response dropped, no `master_rvalid_o` asserted, `resp_err_o` set to 1. It stays 1 until reset.
- Simultaneous push and pop (non-full): both take effect, count unchanged.
- Pointers wrap modulo `MAX_OUTSTANDING`. Count width is `$clog2(MAX_OUTSTANDING+1)`.
- The slave returns responses in grant order (OBI rule). The FIFO relies on this.

## Timing
- Request path (`granted_master_i` → `slave_req_o`) is combinational.
- Grant path (`slave_gnt_i` → `master_gnt_o`) is combinational.
- Response path (`slave_rvalid_i` → `master_rvalid_o`) is combinational from the FIFO head register.
- A response is never returned in its own grant cycle. A push becomes visible at the head the cycle after accept, so the earliest response is accept cycle + 1.
- Reset (`rst_i` high at a clock edge):
  - count = 0, read/write pointers = 0, `resp_err_o` = 0;
  - while reset is held, `slave_req_o` and all `master_gnt_o` / `master_rvalid_o` lines are forced low.
- Reset mid-transaction discards all outstanding IDs. The system resets slaves together with the interconnect.

## Structure
- Shared package `obi_interconnect_pkg` holds:
  - `OBI_ADDR_W=32`, `OBI_DATA_W=32`, `OBI_BE_W=4`;
  - the default `MAX_OUTSTANDING`.
- Sub-module `obi_id_fifo`:
  - parameters WIDTH and DEPTH;
  - ports: push, pop, data in, head, full, empty;
  - synchronous active-high reset.
- The top level holds the muxes, the grant/rvalid decoders and the error flag.

## Test plan
- Single read, `MASTERS=3`, `MAX_OUTSTANDING=2`: master 1 selected, gnt same cycle, slave rvalid 2 cycles later with rdata `0xDEADBEEF` → `master_gnt_o[1]` pulses once; `master_rvalid_o[1]` pulses with rdata `0xDEADBEEF`; masters 0 and 2 see nothing.
- Back-to-back: master 2 granted, then master 0 granted the next cycle; two in-order rvalids → rvalid goes to 2, then to 0.
- Full FIFO: two grants with no response yet, `granted_master_i` still 1 → `slave_req_o` = 0. After one rvalid, `slave_req_o` is 1 again the next cycle.
- Slave stalls with `slave_gnt_i` = 0 for 3 cycles → no `master_gnt_o` and no push. The address/we/be/wdata of master 1 are held on the slave outputs.
- Spurious `slave_rvalid_i` with the FIFO empty → no `master_rvalid_o`; `resp_err_o` becomes 1 and persists until `rst_i`.
- Assert `rst_i` with one transaction outstanding, then send an rvalid → the rvalid is dropped and `resp_err_o` = 1; all outputs are 0 during reset.
